atm_account_store: RTL and testbench

//  Parametrised account memory for the ATM datapath: holds per-account balance,
//  PIN, failed-try counter and lock flag; executes one atomic read-modify-write

---
 rtl/atm_account_store.sv | 242 ++++++++++++++++++++++++
 tb/tb_atm_account_store.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/atm_account_store.sv
// Account store for the ATM datapath: one entry per account holding
// {locked, tries, pin, balance}. Runs one read-modify-write transaction at a
// time and enforces the lock, funds and overflow rules itself.
// Pipeline: IDLE accept -> RD (RAM read) -> EX (evaluate, registered)
// -> WB (single write-back) -> RSP (hold response until taken).
module atm_account_store #(
  parameter int NUM_ACCTS = 32,
  parameter int ADDR_W    = 5,
  parameter int BAL_W     = 16,
  parameter int PIN_W     = 16,
  parameter int MAX_TRIES = 3,
  localparam int TW       = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [PIN_W-1:0]  req_pin,
  input  logic [BAL_W-1:0]  req_amount,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [2:0]        rsp_status,
  output logic [BAL_W-1:0]  rsp_balance,
  output logic              rsp_locked,
  output logic [TW-1:0]     rsp_tries
);

  localparam int IW = (NUM_ACCTS > 1) ? $clog2(NUM_ACCTS) : 1;
  localparam int EW = 1 + TW + PIN_W + BAL_W;
  localparam logic [TW-1:0] MAX_T = TW'(MAX_TRIES);
  localparam logic [IW-1:0] LAST_PTR = IW'(NUM_ACCTS - 1);

  localparam logic [2:0] OP_READ      = 3'd0;
  localparam logic [2:0] OP_CHECK_PIN = 3'd1;
  localparam logic [2:0] OP_DEBIT     = 3'd2;
  localparam logic [2:0] OP_CREDIT    = 3'd3;
  localparam logic [2:0] OP_LOCK      = 3'd4;
  localparam logic [2:0] OP_UNLOCK    = 3'd5;
  localparam logic [2:0] OP_INIT      = 3'd6;

  localparam logic [2:0] ST_OK       = 3'd0;
  localparam logic [2:0] ST_BAD_PIN  = 3'd1;
  localparam logic [2:0] ST_LOCKED   = 3'd2;
  localparam logic [2:0] ST_NSF      = 3'd3;
  localparam logic [2:0] ST_OVERFLOW = 3'd4;
  localparam logic [2:0] ST_BAD_ADDR = 3'd5;
  localparam logic [2:0] ST_BAD_OP   = 3'd6;

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_RD, S_EX, S_WB, S_RSP
  } state_t;

  state_t             state_reg, state_next;
  logic [IW-1:0]      ptr_reg;
  logic [2:0]         op_reg;
  logic [ADDR_W-1:0]  addr_reg;
  logic [PIN_W-1:0]   pin_reg;
  logic [BAL_W-1:0]   amount_reg;
  logic [EW-1:0]      rd_data;
  logic [EW-1:0]      wb_data_reg;
  logic               wb_we_reg;
  logic [2:0]         status_reg;
  logic [BAL_W-1:0]   balance_reg;
  logic               locked_reg;
  logic [TW-1:0]      tries_reg;

  logic [EW-1:0]      mem [NUM_ACCTS];
  logic               mem_we;
  logic [IW-1:0]      mem_waddr;
  logic [EW-1:0]      mem_wdata;

  logic               addr_ok;
  logic               cur_locked;
  logic [TW-1:0]      cur_tries;
  logic [PIN_W-1:0]   cur_pin;
  logic [BAL_W-1:0]   cur_bal;
  logic [TW-1:0]      tries_inc;
  logic [BAL_W:0]     sum;

  logic               ev_locked;
  logic [TW-1:0]      ev_tries;
  logic [PIN_W-1:0]   ev_pin;
  logic [BAL_W-1:0]   ev_bal;
  logic [2:0]         ev_status;
  logic               ev_we;

  // Widened compare so NUM_ACCTS == 2**ADDR_W does not truncate to zero.
  assign addr_ok    = ({1'b0, addr_reg} < (ADDR_W + 1)'(NUM_ACCTS));
  assign cur_bal    = rd_data[BAL_W-1:0];
  assign cur_pin    = rd_data[BAL_W +: PIN_W];
  assign cur_tries  = rd_data[BAL_W + PIN_W +: TW];
  assign cur_locked = rd_data[EW-1];
  assign tries_inc  = cur_tries + TW'(1);
  assign sum        = {1'b0, cur_bal} + {1'b0, amount_reg};

  assign req_ready   = (state_reg == S_IDLE);
  assign rsp_valid   = (state_reg == S_RSP);
  assign rsp_status  = status_reg;
  assign rsp_balance = balance_reg;
  assign rsp_locked  = locked_reg;
  assign rsp_tries   = tries_reg;

  // Single RAM write port: the clear sweep or the transaction write-back.
  assign mem_we    = (state_reg == S_CLEAR) || ((state_reg == S_WB) && wb_we_reg);
  assign mem_waddr = (state_reg == S_CLEAR) ? ptr_reg : addr_reg[IW-1:0];
  assign mem_wdata = (state_reg == S_CLEAR) ? '0 : wb_data_reg;

  // Next-state sequencing of the transaction pipeline.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_CLEAR: if (ptr_reg == LAST_PTR) state_next = S_IDLE;
      S_IDLE:  if (req_valid) state_next = S_RD;
      S_RD:    state_next = S_EX;
      S_EX:    state_next = S_WB;
      S_WB:    state_next = S_RSP;
      S_RSP:   if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_CLEAR;
    endcase
  end

  // Apply the account rules to the entry read in RD; bad addresses report zeros.
  always_comb begin
    ev_locked = cur_locked;
    ev_tries  = cur_tries;
    ev_pin    = cur_pin;
    ev_bal    = cur_bal;
    ev_status = ST_OK;
    ev_we     = 1'b0;
    if (!addr_ok) begin
      ev_status = ST_BAD_ADDR;
      ev_locked = 1'b0;
      ev_tries  = '0;
      ev_pin    = '0;
      ev_bal    = '0;
    end else begin
      case (op_reg)
        OP_READ: ev_status = ST_OK;
        OP_CHECK_PIN: begin
          if (cur_locked) begin
            ev_status = ST_LOCKED;
          end else if (pin_reg == cur_pin) begin
            ev_tries = '0;
            ev_we    = 1'b1;
          end else begin
            ev_tries = tries_inc;
            ev_we    = 1'b1;
            if (tries_inc == MAX_T) begin
              ev_locked = 1'b1;
              ev_status = ST_LOCKED;
            end else begin
              ev_status = ST_BAD_PIN;
            end
          end
        end
        OP_DEBIT: begin
          if (cur_locked) begin
            ev_status = ST_LOCKED;
          end else if (amount_reg > cur_bal) begin
            ev_status = ST_NSF;
          end else begin
            ev_bal = cur_bal - amount_reg;
            ev_we  = 1'b1;
          end
        end
        OP_CREDIT: begin
          if (cur_locked) begin
            ev_status = ST_LOCKED;
          end else if (sum[BAL_W]) begin
            ev_status = ST_OVERFLOW;
          end else begin
            ev_bal = sum[BAL_W-1:0];
            ev_we  = 1'b1;
          end
        end
        OP_LOCK: begin
          ev_locked = 1'b1;
          ev_we     = 1'b1;
        end
        OP_UNLOCK: begin
          ev_locked = 1'b0;
          ev_tries  = '0;
          ev_we     = 1'b1;
        end
        OP_INIT: begin
          ev_pin    = pin_reg;
          ev_bal    = amount_reg;
          ev_locked = 1'b0;
          ev_tries  = '0;
          ev_we     = 1'b1;
        end
        default: ev_status = ST_BAD_OP;
      endcase
    end
  end

  // Control state, request latch, registered evaluation and response fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= S_CLEAR;
      ptr_reg     <= '0;
      op_reg      <= '0;
      addr_reg    <= '0;
      pin_reg     <= '0;
      amount_reg  <= '0;
      wb_data_reg <= '0;
      wb_we_reg   <= 1'b0;
      status_reg  <= '0;
      balance_reg <= '0;
      locked_reg  <= 1'b0;
      tries_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (state_reg == S_CLEAR) begin
        ptr_reg <= (ptr_reg == LAST_PTR) ? '0 : ptr_reg + IW'(1);
      end
      if ((state_reg == S_IDLE) && req_valid) begin
        op_reg     <= req_op;
        addr_reg   <= req_addr;
        pin_reg    <= req_pin;
        amount_reg <= req_amount;
      end
      if (state_reg == S_EX) begin
        wb_data_reg <= {ev_locked, ev_tries, ev_pin, ev_bal};
        wb_we_reg   <= ev_we;
        status_reg  <= ev_status;
        balance_reg <= ev_bal;
        locked_reg  <= ev_locked;
        tries_reg   <= ev_tries;
      end
    end
  end

  // Account RAM: one write port, registered read of the latched address.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if ((state_reg == S_RD) && addr_ok) rd_data <= mem[addr_reg[IW-1:0]];
  end

endmodule

// File: tb/tb_atm_account_store.sv
// Bench for atm_account_store: directed transactions with literal expectations,
// plus a monitor that checks every valid response cycle against an
// account-level model updated at each accepted request.
module tb_atm_account_store;

  localparam int NA = 32;
  localparam int AW = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = '0;
  logic [AW-1:0] req_addr = '0;
  logic [15:0] req_pin = '0;
  logic [15:0] req_amount = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [2:0]  rsp_status;
  logic [15:0] rsp_balance;
  logic        rsp_locked;
  logic [1:0]  rsp_tries;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  atm_account_store #(
    .NUM_ACCTS(NA), .ADDR_W(AW), .BAL_W(16), .PIN_W(16), .MAX_TRIES(3)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_pin(req_pin), .req_amount(req_amount),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_status(rsp_status),
    .rsp_balance(rsp_balance), .rsp_locked(rsp_locked), .rsp_tries(rsp_tries)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- account-level model ----------------
  typedef struct {
    int st; int bal; int lk; int tr; int cyc;
  } exp_t;

  int   m_bal [NA];
  int   m_pin [NA];
  int   m_tr  [NA];
  int   m_lk  [NA];
  exp_t exp_q [$];
  bit   head_seen = 1'b0;

  function automatic exp_t model(int op, int a, int pin, int amt);
    exp_t e;
    e.cyc = 0;
    e.st  = 0;
    if (a >= NA) begin
      e.st = 5; e.bal = 0; e.lk = 0; e.tr = 0;
      return e;
    end
    case (op)
      1: begin
        if (m_lk[a] != 0) e.st = 2;
        else if (pin == m_pin[a]) m_tr[a] = 0;
        else begin
          m_tr[a] = m_tr[a] + 1;
          if (m_tr[a] >= 3) begin m_lk[a] = 1; e.st = 2; end
          else e.st = 1;
        end
      end
      2: begin
        if (m_lk[a] != 0) e.st = 2;
        else if (amt > m_bal[a]) e.st = 3;
        else m_bal[a] = m_bal[a] - amt;
      end
      3: begin
        if (m_lk[a] != 0) e.st = 2;
        else if (m_bal[a] + amt > 65535) e.st = 4;
        else m_bal[a] = m_bal[a] + amt;
      end
      4: m_lk[a] = 1;
      5: begin m_lk[a] = 0; m_tr[a] = 0; end
      6: begin m_pin[a] = pin; m_bal[a] = amt; m_lk[a] = 0; m_tr[a] = 0; end
      7: e.st = 6;
      default: e.st = 0;
    endcase
    e.bal = m_bal[a]; e.lk = m_lk[a]; e.tr = m_tr[a];
    return e;
  endfunction

  // Compare every valid response cycle with the model; log accepts.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      head_seen = 1'b0;
      for (int i = 0; i < NA; i++) begin
        m_bal[i] = 0; m_pin[i] = 0; m_tr[i] = 0; m_lk[i] = 0;
      end
    end else begin
      if (rsp_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_rsp: rsp_valid=1 with nothing in flight at cycle %0d", cyc);
        end else begin
          if (!head_seen) begin
            head_seen = 1'b1;
            vectors++;
            if (cyc != exp_q[0].cyc) begin
              miscompares++;
              $display("FAIL rsp_latency: first valid at cycle %0d, required %0d", cyc, exp_q[0].cyc);
            end
          end
          if (int'(rsp_status) != exp_q[0].st || int'(rsp_balance) != exp_q[0].bal ||
              int'(rsp_locked) != exp_q[0].lk || int'(rsp_tries) != exp_q[0].tr || req_ready) begin
            miscompares++;
            $display("FAIL model_rsp: got st=%0d bal=%0d lk=%0d tr=%0d rdy=%0d, required st=%0d bal=%0d lk=%0d tr=%0d rdy=0",
                     rsp_status, rsp_balance, rsp_locked, rsp_tries, req_ready,
                     exp_q[0].st, exp_q[0].bal, exp_q[0].lk, exp_q[0].tr);
          end
          if (rsp_ready) begin
            void'(exp_q.pop_front());
            head_seen = 1'b0;
          end
        end
      end
      if (req_valid && req_ready) begin
        exp_t e;
        e = model(int'(req_op), int'(req_addr), int'(req_pin), int'(req_amount));
        e.cyc = cyc + 4;
        exp_q.push_back(e);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic check(input string nm, input int got, input int req);
    vectors++;
    if (got != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, required %0d", nm, got, req);
    end
  endtask

  task automatic send(input int op, input int a, input int pin, input int amt);
    int n = 0;
    @(posedge clk); #1;
    while (!req_ready && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (!req_ready) check("req_ready_timeout", 0, 1);
    req_valid  = 1'b1;
    req_op     = 3'(op);
    req_addr   = AW'(a);
    req_pin    = 16'(pin);
    req_amount = 16'(amt);
    @(posedge clk); #1;
    req_valid  = 1'b0;
  endtask

  // Issue one request, wait (bounded) for its response, compare with literals.
  task automatic txn(input string nm, input int op, input int a, input int pin,
                     input int amt, input int es, input int eb, input int el, input int et);
    bit got = 1'b0;
    send(op, a, pin, amt);
    for (int i = 0; i < 12 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid) got = 1'b1;
    end
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL %s: no response within bound, required st=%0d", nm, es);
    end else if (int'(rsp_status) != es || int'(rsp_balance) != eb ||
                 int'(rsp_locked) != el || int'(rsp_tries) != et) begin
      miscompares++;
      $display("FAIL %s: got st=%0d bal=%0d lk=%0d tr=%0d, required st=%0d bal=%0d lk=%0d tr=%0d",
               nm, rsp_status, rsp_balance, rsp_locked, rsp_tries, es, eb, el, et);
    end else begin
      $display("txn %s: st=%0d bal=%0d lk=%0d tr=%0d", nm, rsp_status, rsp_balance, rsp_locked, rsp_tries);
    end
    while (rsp_valid && !rsp_ready) @(negedge clk);
    @(posedge clk); #1;
  endtask

  // Count cycles from reset release until req_ready rises.
  task automatic wait_clear(input string nm);
    int n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check(nm, n, NA);
    $display("txn %s: clear sweep took %0d cycles", nm, n);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    bit [2:0]  s_st;
    bit [15:0] s_bal;
    bit        stable;
    // 1: reset values, clear sweep length, fresh entry
    repeat (3) @(negedge clk);
    check("rst_req_ready", int'(req_ready), 0);
    check("rst_rsp_valid", int'(rsp_valid), 0);
    check("rst_rsp_fields", int'({rsp_status, rsp_balance, rsp_locked, rsp_tries}), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_clear("clear_len_1");
    txn("read31", 0, 31, 0, 0, 0, 0, 0, 0);

    // 2: funds rules
    txn("init5",      6, 5, 1234, 500, 0, 500, 0, 0);
    txn("debit200",   2, 5, 0, 200, 0, 300, 0, 0);
    txn("debit301",   2, 5, 0, 301, 3, 300, 0, 0);
    txn("debit0",     2, 5, 0, 0,   0, 300, 0, 0);
    txn("debit300",   2, 5, 0, 300, 0, 0,   0, 0);

    // 3: overflow boundary
    txn("init7",      6, 7, 16'h1111, 65000, 0, 65000, 0, 0);
    txn("credit535",  3, 7, 0, 535, 0, 65535, 0, 0);
    txn("credit1",    3, 7, 0, 1,   4, 65535, 0, 0);

    // 4: PIN tries and lock
    txn("init9",      6, 9, 4321, 1000, 0, 1000, 0, 0);
    txn("pin_bad1",   1, 9, 1, 0,    1, 1000, 0, 1);
    txn("pin_bad2",   1, 9, 2, 0,    1, 1000, 0, 2);
    txn("pin_ok",     1, 9, 4321, 0, 0, 1000, 0, 0);
    txn("pin_bad_a",  1, 9, 7, 0,    1, 1000, 0, 1);
    txn("pin_bad_b",  1, 9, 7, 0,    1, 1000, 0, 2);
    txn("pin_bad_c",  1, 9, 7, 0,    2, 1000, 1, 3);
    txn("pin_locked", 1, 9, 4321, 0, 2, 1000, 1, 3);
    txn("debit_lk",   2, 9, 0, 10,   2, 1000, 1, 3);
    txn("unlock9",    5, 9, 0, 0,    0, 1000, 0, 0);
    txn("lock9",      4, 9, 0, 0,    0, 1000, 1, 0);
    txn("lock9_again",4, 9, 0, 0,    0, 1000, 1, 0);
    txn("credit_lk",  3, 9, 0, 5,    2, 1000, 1, 0);
    txn("unlock9b",   5, 9, 0, 0,    0, 1000, 0, 0);
    txn("credit9",    3, 9, 0, 5,    0, 1005, 0, 0);

    // 5: bad address / bad op leave entries alone
    txn("read40",     0, 40, 0, 0,    5, 0, 0, 0);
    txn("init40",     6, 40, 9, 777,  5, 0, 0, 0);
    txn("badop7",     7, 7, 0, 0,     6, 65535, 0, 0);
    txn("read8",      0, 8, 0, 0,     0, 0, 0, 0);
    txn("read7",      0, 7, 0, 0,     0, 65535, 0, 0);
    txn("read5",      0, 5, 0, 0,     0, 0, 0, 0);

    // 6a: response back-pressure
    rsp_ready = 1'b0;
    send(2, 7, 0, 5);
    begin
      bit got = 1'b0;
      for (int i = 0; i < 12 && !got; i++) begin
        @(negedge clk);
        if (rsp_valid) got = 1'b1;
      end
      check("stall_rsp_seen", int'(got), 1);
      check("stall_status", int'(rsp_status), 0);
      check("stall_balance", int'(rsp_balance), 65530);
      s_st  = rsp_status;
      s_bal = rsp_balance;
      for (int i = 0; i < 5; i++) begin
        @(negedge clk);
        stable = rsp_valid && !req_ready && (rsp_status == s_st) && (rsp_balance == s_bal);
        check("stall_hold", int'(stable), 1);
      end
      $display("txn stall_debit: st=%0d bal=%0d held 5 cycles", s_st, s_bal);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("stall_release", int'(rsp_valid), 0);

    // 6b: reset during EX drops the transaction and re-runs the sweep
    send(2, 7, 0, 30);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    check("rst_ex_valid", int'(rsp_valid), 0);
    check("rst_ex_ready", int'(req_ready), 0);
    check("rst_ex_bal", int'(rsp_balance), 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    wait_clear("clear_len_2");
    txn("read7_after_rst", 0, 7, 0, 0, 0, 0, 0, 0);
    txn("read9_after_rst", 0, 9, 0, 0, 0, 0, 0, 0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
